wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 135 +++++++++++++
 tb/tb_wb_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter: one holding slot per result source (alu, fpu, mem) feeding a
// single registered register-file write port, fixed priority mem > fpu > alu with aging.
module wb_arbiter #(
    parameter int AGE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [6:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        fpu_valid,
    output logic        fpu_ready,
    input  logic [6:0]  fpu_rd,
    input  logic [31:0] fpu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [6:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic [6:0]  wb_rd,
    output logic [31:0] rddata,
    output logic        we
);
    localparam int AW = $clog2(AGE_LIMIT + 1);
    localparam logic [AW-1:0] AGE_MAX = AW'(AGE_LIMIT);

    // Handshake: a source transfers on a rising edge where s_valid and s_ready are both
    // high; s_ready depends only on slot state and reset, never on s_valid.

    // Source index: 0 = alu, 1 = fpu, 2 = mem (higher index wins fixed priority).
    logic [2:0]    in_valid;
    logic [6:0]    in_rd   [3];
    logic [31:0]   in_data [3];

    logic [2:0]    slot_valid_q, slot_valid_d;
    logic [6:0]    slot_rd_q   [3];
    logic [6:0]    slot_rd_d   [3];
    logic [31:0]   slot_data_q [3];
    logic [31:0]   slot_data_d [3];
    logic [AW-1:0] slot_age_q  [3];
    logic [AW-1:0] slot_age_d  [3];

    logic [6:0]    wb_rd_q, wb_rd_d;
    logic [31:0]   rddata_q, rddata_d;
    logic          we_q, we_d;

    logic [2:0]    aged, cand, grant, ready, accept;

    always_comb begin
        in_valid   = {mem_valid, fpu_valid, alu_valid};
        in_rd[0]   = alu_rd;
        in_rd[1]   = fpu_rd;
        in_rd[2]   = mem_rd;
        in_data[0] = alu_data;
        in_data[1] = fpu_data;
        in_data[2] = mem_data;
    end

    // Entries that waited AGE_LIMIT cycles override plain priority among themselves.
    always_comb begin
        aged = 3'b000;
        for (int i = 0; i < 3; i++) begin
            aged[i] = slot_valid_q[i] && (slot_age_q[i] == AGE_MAX);
        end
        cand  = (|aged) ? aged : slot_valid_q;
        grant = cand[2] ? 3'b100 : cand[1] ? 3'b010 : cand[0] ? 3'b001 : 3'b000;
        ready  = {3{rst}} & (~slot_valid_q | grant);
        accept = in_valid & ready;
    end

    assign alu_ready = ready[0];
    assign fpu_ready = ready[1];
    assign mem_ready = ready[2];

    always_comb begin
        slot_valid_d = slot_valid_q;
        for (int i = 0; i < 3; i++) begin
            slot_rd_d[i]   = slot_rd_q[i];
            slot_data_d[i] = slot_data_q[i];
            slot_age_d[i]  = slot_age_q[i];
            if (accept[i] && in_rd[i][6]) begin
                slot_valid_d[i] = 1'b1;
                slot_rd_d[i]    = in_rd[i];
                slot_data_d[i]  = in_data[i];
                slot_age_d[i]   = '0;
            end else if (accept[i] || grant[i]) begin
                // Results without write-enable are consumed but never stored.
                slot_valid_d[i] = 1'b0;
                slot_age_d[i]   = '0;
            end else if (slot_valid_q[i] && (slot_age_q[i] != AGE_MAX)) begin
                slot_age_d[i] = slot_age_q[i] + AW'(1);
            end
        end
    end

    always_comb begin
        we_d     = |grant;
        wb_rd_d  = wb_rd_q;
        rddata_d = rddata_q;
        for (int i = 0; i < 3; i++) begin
            if (grant[i]) begin
                wb_rd_d  = slot_rd_q[i];
                rddata_d = slot_data_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_valid_q <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                slot_rd_q[i]   <= '0;
                slot_data_q[i] <= '0;
                slot_age_q[i]  <= '0;
            end
            wb_rd_q  <= '0;
            rddata_q <= '0;
            we_q     <= 1'b0;
        end else begin
            slot_valid_q <= slot_valid_d;
            for (int i = 0; i < 3; i++) begin
                slot_rd_q[i]   <= slot_rd_d[i];
                slot_data_q[i] <= slot_data_d[i];
                slot_age_q[i]  <= slot_age_d[i];
            end
            wb_rd_q  <= wb_rd_d;
            rddata_q <= rddata_d;
            we_q     <= we_d;
        end
    end

    assign wb_rd  = wb_rd_q;
    assign rddata = rddata_q;
    assign we     = we_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector table for single-edge behaviour plus
// hand-written sequences for aging and back-to-back replacement.
module tb_wb_arbiter;
    logic        clk;
    logic        rst;
    logic        alu_valid, fpu_valid, mem_valid;
    logic        alu_ready, fpu_ready, mem_ready;
    logic [6:0]  alu_rd, fpu_rd, mem_rd;
    logic [31:0] alu_data, fpu_data, mem_data;
    logic [6:0]  wb_rd;
    logic [31:0] rddata;
    logic        we;

    int n_chk  = 0;
    int n_pass = 0;

    wb_arbiter #(.AGE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_rd(fpu_rd), .fpu_data(fpu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_rd(wb_rd), .rddata(rddata), .we(we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [2:0]  v;        // {mem, fpu, alu}
        logic [6:0]  ra, rf, rm;
        logic [31:0] da, df, dm;
        logic [2:0]  exp_rdy;  // {mem, fpu, alu}, sampled before the edge
        logic        exp_we;   // registered outputs, sampled after the edge
        logic [6:0]  exp_rd;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];
    logic [38:0] exp_q[$];

    function automatic vec_t mk(logic r, logic [2:0] v, logic [6:0] ra, logic [6:0] rf,
                                logic [6:0] rm, logic [31:0] da, logic [31:0] df,
                                logic [31:0] dm, logic [2:0] rdy, logic w,
                                logic [6:0] er, logic [31:0] ed);
        vec_t t;
        t.r = r; t.v = v; t.ra = ra; t.rf = rf; t.rm = rm;
        t.da = da; t.df = df; t.dm = dm;
        t.exp_rdy = rdy; t.exp_we = w; t.exp_rd = er; t.exp_data = ed;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; fpu_valid = 0; mem_valid = 0;
        alu_rd = '0; fpu_rd = '0; mem_rd = '0;
        alu_data = '0; fpu_data = '0; mem_data = '0;
    endtask

    logic [2:0]  mem_rdy_exp;
    logic [6:0]  e_rd;
    logic [31:0] e_data;
    logic [38:0] e;
    logic        seq_mem_rdy [9];
    logic        seq_alu_rdy [9];
    int          mem_idx;

    initial begin
        rst = 1'b0;
        idle_inputs();

        // reset, reset with garbage inputs, release
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 7'h00, 32'h0));
        vecs.push_back(mk(0, 3'b111, 7'h7F, 7'h7F, 7'h7F, 32'hDEAD, 32'hBEEF, 32'hCAFE, 3'b000, 0, 7'h00, 32'h0));
        vecs.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 0, 7'h00, 32'h0));
        // single alu write, two-edge latency
        vecs.push_back(mk(1, 3'b001, 7'h45, 0, 0, 32'h1234, 0, 0, 3'b111, 0, 7'h00, 32'h0));
        vecs.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 1, 7'h45, 32'h1234));
        vecs.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 0, 7'h45, 32'h1234));
        // all three at once drain mem, fpu, alu
        vecs.push_back(mk(1, 3'b111, 7'h41, 7'h62, 7'h43, 32'hA1, 32'hF2, 32'hE3, 3'b111, 0, 7'h45, 32'h1234));
        vecs.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b100, 1, 7'h43, 32'hE3));
        vecs.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b110, 1, 7'h62, 32'hF2));
        vecs.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 1, 7'h41, 32'hA1));
        vecs.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 0, 7'h41, 32'hA1));
        // write-enable clear: accepted and dropped
        vecs.push_back(mk(1, 3'b010, 0, 7'h05, 0, 0, 32'h55, 0, 3'b111, 0, 7'h41, 32'hA1));
        vecs.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 0, 7'h41, 32'hA1));
        // fill all slots, then reset for one edge
        vecs.push_back(mk(1, 3'b111, 7'h51, 7'h52, 7'h53, 32'h1, 32'h2, 32'h3, 3'b111, 0, 7'h41, 32'hA1));
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 7'h00, 32'h0));
        vecs.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 0, 7'h00, 32'h0));
        vecs.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 0, 7'h00, 32'h0));

        foreach (vecs[i]) begin
            rst = vecs[i].r;
            alu_valid = vecs[i].v[0]; fpu_valid = vecs[i].v[1]; mem_valid = vecs[i].v[2];
            alu_rd = vecs[i].ra; fpu_rd = vecs[i].rf; mem_rd = vecs[i].rm;
            alu_data = vecs[i].da; fpu_data = vecs[i].df; mem_data = vecs[i].dm;
            #1;
            chk($sformatf("v%0d_ready", i), {29'b0, mem_ready, fpu_ready, alu_ready}, {29'b0, vecs[i].exp_rdy});
            @(posedge clk); #1;
            chk($sformatf("v%0d_we", i), {31'b0, we}, {31'b0, vecs[i].exp_we});
            chk($sformatf("v%0d_wb_rd", i), {25'b0, wb_rd}, {25'b0, vecs[i].exp_rd});
            chk($sformatf("v%0d_rddata", i), rddata, vecs[i].exp_data);
        end

        // Aging: alu entry parked behind a busy mem stream wins once its age hits 4.
        seq_mem_rdy = '{1, 1, 1, 1, 1, 0, 1, 1, 1};
        seq_alu_rdy = '{1, 0, 0, 0, 0, 1, 1, 1, 1};
        for (int k = 0; k < 4; k++) exp_q.push_back({7'h40 + 7'(k), 32'h100 + 32'(k)});
        exp_q.push_back({7'h4A, 32'hAA});
        for (int k = 4; k < 7; k++) exp_q.push_back({7'h40 + 7'(k), 32'h100 + 32'(k)});
        mem_idx = 0;
        for (int c = 0; c < 9; c++) begin
            idle_inputs();
            alu_valid = (c == 0);
            alu_rd    = 7'h4A;
            alu_data  = 32'hAA;
            mem_valid = (c <= 7);
            mem_rd    = 7'h40 + 7'(mem_idx);
            mem_data  = 32'h100 + 32'(mem_idx);
            #1;
            chk($sformatf("age_c%0d_mem_ready", c), {31'b0, mem_ready}, {31'b0, seq_mem_rdy[c]});
            chk($sformatf("age_c%0d_alu_ready", c), {31'b0, alu_ready}, {31'b0, seq_alu_rdy[c]});
            @(posedge clk); #1;
            if (c == 0) begin
                chk("age_c0_we", {31'b0, we}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                e_rd = e[38:32];
                e_data = e[31:0];
                chk($sformatf("age_c%0d_we", c), {31'b0, we}, 32'h1);
                chk($sformatf("age_c%0d_wb_rd", c), {25'b0, wb_rd}, {25'b0, e_rd});
                chk($sformatf("age_c%0d_rddata", c), rddata, e_data);
            end
            if (mem_valid && seq_mem_rdy[c]) mem_idx++;
        end
        idle_inputs();
        @(posedge clk); #1;
        chk("age_drain_we", {31'b0, we}, 32'h0);

        // Granted mem slot refilled in the same cycle: back-to-back writes.
        idle_inputs();
        mem_valid = 1; mem_rd = 7'h61; mem_data = 32'hD1;
        @(posedge clk); #1;
        chk("b2b_first_we", {31'b0, we}, 32'h0);
        mem_valid = 1; mem_rd = 7'h62; mem_data = 32'hD2;
        #1;
        mem_rdy_exp = 3'b111;
        chk("b2b_mem_ready", {29'b0, mem_ready, fpu_ready, alu_ready}, {29'b0, mem_rdy_exp});
        @(posedge clk); #1;
        chk("b2b_w1_we", {31'b0, we}, 32'h1);
        chk("b2b_w1_rd", {25'b0, wb_rd}, 32'h61);
        chk("b2b_w1_data", rddata, 32'hD1);
        idle_inputs();
        @(posedge clk); #1;
        chk("b2b_w2_we", {31'b0, we}, 32'h1);
        chk("b2b_w2_rd", {25'b0, wb_rd}, 32'h62);
        chk("b2b_w2_data", rddata, 32'hD2);
        @(posedge clk); #1;
        chk("b2b_end_we", {31'b0, we}, 32'h0);
        chk("b2b_end_rd_hold", {25'b0, wb_rd}, 32'h62);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
